gmii_adapter_array: RTL and testbench

//  Parametrised N-port GMII adapter between PHY-side GMII and the TSN switch core, all ports on one clock.
//  Per-port enable gates each direction independently and is applied only on frame boundaries, so no partial frame is forwarded.

---
 rtl/gmii_adapter_array.sv | 189 ++++++++++++++++++
 tb/tb_gmii_adapter_array.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_adapter_array.sv
// N-port GMII adapter: per-lane frame-boundary enable gating, sticky error, fixed-latency pipeline.
// Optional per-port rx frame/error statistics are enabled by defining GAD_STATS_EN.
module gmii_adapter_array #(
  parameter int PORT_NUM = 5,
  parameter int DATA_W   = 8,
  parameter int PIPE_DLY = 2,
  parameter int CNT_W    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [PORT_NUM-1:0]          iv_port_en,
  input  logic [PORT_NUM-1:0]          iv_gmii_rx_dv,
  input  logic [PORT_NUM-1:0]          iv_gmii_rx_er,
  input  logic [PORT_NUM*DATA_W-1:0]   iv_gmii_rxd,
  output logic [PORT_NUM-1:0]          ov_gmii_rx_dv_adp2tsnchip,
  output logic [PORT_NUM-1:0]          ov_gmii_rx_er_adp2tsnchip,
  output logic [PORT_NUM*DATA_W-1:0]   ov_gmii_rxd_adp2tsnchip,
  input  logic [PORT_NUM-1:0]          iv_gmii_tx_en_tsnchip2adp,
  input  logic [PORT_NUM-1:0]          iv_gmii_tx_er_tsnchip2adp,
  input  logic [PORT_NUM*DATA_W-1:0]   iv_gmii_txd_tsnchip2adp,
  output logic [PORT_NUM-1:0]          ov_gmii_tx_en,
  output logic [PORT_NUM-1:0]          ov_gmii_tx_er,
  output logic [PORT_NUM*DATA_W-1:0]   ov_gmii_txd,
  output logic [PORT_NUM*CNT_W-1:0]    ov_rx_frm_cnt,
  output logic [PORT_NUM*CNT_W-1:0]    ov_rx_err_cnt
);

  localparam int LANE_NUM = 2 * PORT_NUM;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2,
    ST_TERM = 2'd3
  } lane_state_t;

  // Lanes 0..PORT_NUM-1 are rx, PORT_NUM..LANE_NUM-1 are tx; both share the port enable.
  logic [LANE_NUM-1:0]        lane_v_s;
  logic [LANE_NUM-1:0]        lane_e_s;
  logic [LANE_NUM-1:0]        lane_en_s;
  logic [LANE_NUM*DATA_W-1:0] lane_d_s;
  logic [LANE_NUM-1:0]        lane_out_v_s;
  logic [LANE_NUM-1:0]        lane_out_e_s;
  logic [LANE_NUM*DATA_W-1:0] lane_out_d_s;

  assign lane_v_s  = {iv_gmii_tx_en_tsnchip2adp, iv_gmii_rx_dv};
  assign lane_e_s  = {iv_gmii_tx_er_tsnchip2adp, iv_gmii_rx_er};
  assign lane_d_s  = {iv_gmii_txd_tsnchip2adp, iv_gmii_rxd};
  assign lane_en_s = {iv_port_en, iv_port_en};

  genvar g;
  generate
    for (g = 0; g < LANE_NUM; g++) begin : g_lane
      lane_state_t         state_r;
      logic                sticky_r;
      logic [PIPE_DLY-1:0] pv_r;
      logic [PIPE_DLY-1:0] pe_r;
      logic [DATA_W-1:0]   pd_r [PIPE_DLY];
      logic                v_s;
      logic                e_s;
      logic                en_s;
      logic [DATA_W-1:0]   d_s;

      assign v_s  = lane_v_s[g];
      assign e_s  = lane_e_s[g];
      assign en_s = lane_en_s[g];
      assign d_s  = lane_d_s[g*DATA_W +: DATA_W];

      // Lane FSM at the pipeline input; stage 0 is its registered output, later stages only delay.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_r  <= ST_IDLE;
          sticky_r <= 1'b0;
          pv_r     <= {PIPE_DLY{1'b0}};
          pe_r     <= {PIPE_DLY{1'b0}};
          for (int i = 0; i < PIPE_DLY; i++) begin
            pd_r[i] <= {DATA_W{1'b0}};
          end
        end else begin
          for (int i = PIPE_DLY - 1; i > 0; i--) begin
            pv_r[i] <= pv_r[i-1];
            pe_r[i] <= pe_r[i-1];
            pd_r[i] <= pd_r[i-1];
          end
          pv_r[0] <= 1'b0;
          pe_r[0] <= 1'b0;
          pd_r[0] <= {DATA_W{1'b0}};
          case (state_r)
            ST_IDLE: begin
              if (v_s) begin
                if (en_s) begin
                  state_r  <= ST_FWD;
                  sticky_r <= e_s;
                  pv_r[0]  <= 1'b1;
                  pe_r[0]  <= e_s;
                  pd_r[0]  <= d_s;
                end else begin
                  state_r  <= ST_DROP;
                  sticky_r <= 1'b0;
                end
              end else begin
                sticky_r <= 1'b0;
              end
            end
            ST_FWD: begin
              if (!v_s) begin
                state_r  <= ST_IDLE;
                sticky_r <= 1'b0;
              end else if (!en_s) begin
                // Disabled mid-frame: close the frame with one poisoned cycle.
                state_r  <= ST_TERM;
                sticky_r <= 1'b0;
                pv_r[0]  <= 1'b1;
                pe_r[0]  <= 1'b1;
              end else begin
                sticky_r <= sticky_r | e_s;
                pv_r[0]  <= 1'b1;
                pe_r[0]  <= sticky_r | e_s;
                pd_r[0]  <= d_s;
              end
            end
            ST_DROP, ST_TERM: begin
              if (!v_s) begin
                state_r <= ST_IDLE;
              end
            end
            default: begin
              state_r  <= ST_IDLE;
              sticky_r <= 1'b0;
            end
          endcase
        end
      end

      assign lane_out_v_s[g]                   = pv_r[PIPE_DLY-1];
      assign lane_out_e_s[g]                   = pe_r[PIPE_DLY-1];
      assign lane_out_d_s[g*DATA_W +: DATA_W]  = pd_r[PIPE_DLY-1];
    end
  endgenerate

  assign ov_gmii_rx_dv_adp2tsnchip = lane_out_v_s[PORT_NUM-1:0];
  assign ov_gmii_rx_er_adp2tsnchip = lane_out_e_s[PORT_NUM-1:0];
  assign ov_gmii_rxd_adp2tsnchip   = lane_out_d_s[PORT_NUM*DATA_W-1:0];
  assign ov_gmii_tx_en             = lane_out_v_s[LANE_NUM-1:PORT_NUM];
  assign ov_gmii_tx_er             = lane_out_e_s[LANE_NUM-1:PORT_NUM];
  assign ov_gmii_txd               = lane_out_d_s[LANE_NUM*DATA_W-1:PORT_NUM*DATA_W];

`ifdef GAD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  generate
    for (g = 0; g < PORT_NUM; g++) begin : g_stat
      logic             prev_v_r;
      logic             prev_e_r;
      logic [CNT_W-1:0] frm_r;
      logic [CNT_W-1:0] err_r;

      // Count on the first idle output cycle after a forwarded frame; sticky err makes the last cycle decisive.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          prev_v_r <= 1'b0;
          prev_e_r <= 1'b0;
          frm_r    <= {CNT_W{1'b0}};
          err_r    <= {CNT_W{1'b0}};
        end else begin
          prev_v_r <= lane_out_v_s[g];
          prev_e_r <= lane_out_e_s[g];
          if (prev_v_r && !lane_out_v_s[g]) begin
            if (frm_r != CNT_MAX) begin
              frm_r <= frm_r + CNT_ONE;
            end
            if (prev_e_r && (err_r != CNT_MAX)) begin
              err_r <= err_r + CNT_ONE;
            end
          end
        end
      end

      assign ov_rx_frm_cnt[g*CNT_W +: CNT_W] = frm_r;
      assign ov_rx_err_cnt[g*CNT_W +: CNT_W] = err_r;
    end
  endgenerate
`else
  assign ov_rx_frm_cnt = {(PORT_NUM*CNT_W){1'b0}};
  assign ov_rx_err_cnt = {(PORT_NUM*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_gmii_adapter_array.sv
// Self-checking bench for gmii_adapter_array: directed scenarios then randomized traffic,
// all checked every cycle against a frame-level model (stats expectations follow GAD_STATS_EN).
module tb_gmii_adapter_array;
  localparam int PORT_NUM = 5;
  localparam int DATA_W   = 8;
  localparam int PIPE_DLY = 2;
  localparam int CNT_W    = 4;
  localparam int LANES    = 2 * PORT_NUM;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  logic [PORT_NUM-1:0]        port_en;
  logic [PORT_NUM-1:0]        rx_dv, rx_er, tx_en, tx_er;
  logic [PORT_NUM*DATA_W-1:0] rxd, txd;
  logic [PORT_NUM-1:0]        rx_dv_o, rx_er_o, tx_en_o, tx_er_o;
  logic [PORT_NUM*DATA_W-1:0] rxd_o, txd_o;
  logic [PORT_NUM*CNT_W-1:0]  frm_o, err_o;

  gmii_adapter_array #(.PORT_NUM(PORT_NUM), .DATA_W(DATA_W), .PIPE_DLY(PIPE_DLY), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .iv_port_en(port_en),
    .iv_gmii_rx_dv(rx_dv), .iv_gmii_rx_er(rx_er), .iv_gmii_rxd(rxd),
    .ov_gmii_rx_dv_adp2tsnchip(rx_dv_o), .ov_gmii_rx_er_adp2tsnchip(rx_er_o), .ov_gmii_rxd_adp2tsnchip(rxd_o),
    .iv_gmii_tx_en_tsnchip2adp(tx_en), .iv_gmii_tx_er_tsnchip2adp(tx_er), .iv_gmii_txd_tsnchip2adp(txd),
    .ov_gmii_tx_en(tx_en_o), .ov_gmii_tx_er(tx_er_o), .ov_gmii_txd(txd_o),
    .ov_rx_frm_cnt(frm_o), .ov_rx_err_cnt(err_o)
  );

  // Per-lane stimulus (lane < PORT_NUM is rx of that port, else tx of port lane-PORT_NUM)
  bit                in_v [LANES];
  bit                in_e [LANES];
  logic [DATA_W-1:0] in_d [LANES];

  // Frame-level model state and output delay line (index PIPE_DLY-1 = what the outputs show now)
  bit                m_active [LANES];
  bit                m_fwd    [LANES];
  bit                m_sticky [LANES];
  bit                q_v [LANES][PIPE_DLY];
  bit                q_e [LANES][PIPE_DLY];
  logic [DATA_W-1:0] q_d [LANES][PIPE_DLY];
  int unsigned       m_frm [PORT_NUM];
  int unsigned       m_err [PORT_NUM];
  bit                m_last_v [PORT_NUM];
  bit                m_last_e [PORT_NUM];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic drive_dut();
    for (int l = 0; l < LANES; l++) begin
      if (l < PORT_NUM) begin
        rx_dv[l] = in_v[l];
        rx_er[l] = in_e[l];
        rxd[l*DATA_W +: DATA_W] = in_d[l];
      end else begin
        tx_en[l-PORT_NUM] = in_v[l];
        tx_er[l-PORT_NUM] = in_e[l];
        txd[(l-PORT_NUM)*DATA_W +: DATA_W] = in_d[l];
      end
    end
  endtask

  task automatic model_cycle();
    bit ov, oe, en;
    logic [DATA_W-1:0] od;
    int unsigned cmax;
    cmax = (32'd1 << CNT_W) - 32'd1;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (rst) begin
        m_frm[p] = 0; m_err[p] = 0; m_last_v[p] = 1'b0; m_last_e[p] = 1'b0;
      end else begin
`ifdef GAD_STATS_EN
        if (m_last_v[p] && !q_v[p][PIPE_DLY-1]) begin
          if (m_frm[p] < cmax) m_frm[p]++;
          if (m_last_e[p] && m_err[p] < cmax) m_err[p]++;
        end
`endif
        m_last_v[p] = q_v[p][PIPE_DLY-1];
        m_last_e[p] = q_e[p][PIPE_DLY-1];
      end
    end
    for (int l = 0; l < LANES; l++) begin
      en = port_en[l % PORT_NUM];
      ov = 1'b0; oe = 1'b0; od = '0;
      if (rst) begin
        m_active[l] = 1'b0; m_fwd[l] = 1'b0; m_sticky[l] = 1'b0;
        for (int i = 0; i < PIPE_DLY; i++) begin
          q_v[l][i] = 1'b0; q_e[l][i] = 1'b0; q_d[l][i] = '0;
        end
      end else begin
        if (!in_v[l]) begin
          m_active[l] = 1'b0; m_fwd[l] = 1'b0; m_sticky[l] = 1'b0;
        end else if (!m_active[l]) begin
          m_active[l] = 1'b1; m_fwd[l] = en; m_sticky[l] = in_e[l];
          if (en) begin ov = 1'b1; oe = in_e[l]; od = in_d[l]; end
        end else if (m_fwd[l]) begin
          if (!en) begin
            m_fwd[l] = 1'b0; ov = 1'b1; oe = 1'b1; od = '0;
          end else begin
            m_sticky[l] = m_sticky[l] | in_e[l];
            ov = 1'b1; oe = m_sticky[l]; od = in_d[l];
          end
        end
        for (int i = PIPE_DLY - 1; i > 0; i--) begin
          q_v[l][i] = q_v[l][i-1]; q_e[l][i] = q_e[l][i-1]; q_d[l][i] = q_d[l][i-1];
        end
        q_v[l][0] = ov; q_e[l][0] = oe; q_d[l][0] = od;
      end
    end
  endtask

  task automatic compare();
    bit gv, ge;
    logic [DATA_W-1:0] gd;
    logic [CNT_W-1:0] gf, gr, ef, er;
    for (int l = 0; l < LANES; l++) begin
      if (l < PORT_NUM) begin
        gv = rx_dv_o[l]; ge = rx_er_o[l]; gd = rxd_o[l*DATA_W +: DATA_W];
      end else begin
        gv = tx_en_o[l-PORT_NUM]; ge = tx_er_o[l-PORT_NUM]; gd = txd_o[(l-PORT_NUM)*DATA_W +: DATA_W];
      end
      tests++;
      if (gv !== q_v[l][PIPE_DLY-1] || ge !== q_e[l][PIPE_DLY-1] || gd !== q_d[l][PIPE_DLY-1]) begin
        fails++;
        $display("FAIL lane%0d cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h", l, cyc,
                 gv, ge, gd, q_v[l][PIPE_DLY-1], q_e[l][PIPE_DLY-1], q_d[l][PIPE_DLY-1]);
      end
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      gf = frm_o[p*CNT_W +: CNT_W]; gr = err_o[p*CNT_W +: CNT_W];
      ef = m_frm[p][CNT_W-1:0];     er = m_err[p][CNT_W-1:0];
      tests++;
      if (gf !== ef || gr !== er) begin
        fails++;
        $display("FAIL cnt port%0d cyc%0d: got frm=%0d err=%0d, want frm=%0d err=%0d", p, cyc, gf, gr, ef, er);
      end
    end
  endtask

  task automatic step();
    drive_dut();
    model_cycle();
    @(posedge clk);
    @(negedge clk);
    compare();
    cyc++;
  endtask

  task automatic lit(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int l = 0; l < LANES; l++) begin
      in_v[l] = 1'b0; in_e[l] = 1'b0; in_d[l] = '0;
    end
    for (int i = 0; i < n; i++) step();
  endtask

  int unsigned exp_cnt1, exp_sat;
  int left [LANES];
  int gap  [LANES];

  initial begin
`ifdef GAD_STATS_EN
    exp_cnt1 = 1; exp_sat = 32'hF;
`else
    exp_cnt1 = 0; exp_sat = 0;
`endif
    rst = 1'b1; port_en = '0;
    idle(3);
    rst = 1'b0; port_en = 5'h1F;
    idle(2);

    // 1: pass-through on port 2 rx, preamble + SFD + payload
    for (int b = 0; b < 64; b++) begin
      in_v[2] = 1'b1; in_e[2] = 1'b0;
      in_d[2] = (b < 7) ? 8'h55 : (b == 7) ? 8'hD5 : 8'(b * 3 + 1);
      step();
      if (b == 7 + PIPE_DLY - 1) lit("t1_sfd", {rx_dv_o[2], rxd_o[23:16]}, 32'h1D5);
    end
    idle(4);

    // 2: sticky error on port 1 rx
    for (int b = 0; b < 64; b++) begin
      in_v[1] = 1'b1; in_e[1] = (b == 10); in_d[1] = 8'($urandom);
      step();
      if (b == 12 + PIPE_DLY - 1) lit("t2_sticky", rx_er_o[1], 32'h1);
    end
    idle(4);
    lit("t2_er_after", rx_er_o[1], 32'h0);
    lit("t2_errcnt", err_o[1*CNT_W +: CNT_W], exp_cnt1);

    // 3: mid-frame disable on port 3 tx
    for (int b = 0; b < 100; b++) begin
      in_v[PORT_NUM+3] = 1'b1; in_d[PORT_NUM+3] = 8'(b | 1);
      port_en[3] = (b < 20);
      step();
      if (b == 20 + PIPE_DLY - 1) lit("t3_term", {tx_en_o[3], tx_er_o[3], txd_o[31:24]}, 32'h300);
      if (b == 21 + PIPE_DLY - 1) lit("t3_off", tx_en_o[3], 32'h0);
    end
    idle(3);
    for (int b = 0; b < 10; b++) begin
      in_v[PORT_NUM+3] = 1'b1; in_d[PORT_NUM+3] = 8'($urandom); step();
    end
    idle(2);
    port_en[3] = 1'b1;
    idle(1);
    for (int b = 0; b < 10; b++) begin
      in_v[PORT_NUM+3] = 1'b1; in_d[PORT_NUM+3] = 8'($urandom); step();
    end
    idle(4);

    // 4: mid-frame enable on port 4 rx
    port_en[4] = 1'b0;
    for (int b = 0; b < 30; b++) begin
      in_v[4] = 1'b1; in_d[4] = 8'($urandom); port_en[4] = (b >= 5); step();
    end
    idle(2);
    for (int b = 0; b < 10; b++) begin
      in_v[4] = 1'b1; in_d[4] = 8'($urandom); step();
    end
    idle(4);
    lit("t4_frm", frm_o[4*CNT_W +: CNT_W], exp_cnt1);

    // 5: 20 single-cycle frames on port 0 rx
    for (int k = 0; k < 20; k++) begin
      in_v[0] = 1'b1; in_d[0] = 8'(k); step();
      idle(1);
    end
    idle(4);
    lit("t5_sat", frm_o[0 +: CNT_W], exp_sat);

    // 6: reset at byte 30 of a port 2 rx frame, dv held afterwards
    for (int b = 0; b < 50; b++) begin
      in_v[2] = 1'b1; in_d[2] = 8'(b + 64);
      rst = (b == 30);
      step();
      rst = 1'b0;
      if (b == 30) lit("t6_zero", {|rx_dv_o, |rx_er_o, |rxd_o, |tx_en_o, |tx_er_o, |txd_o, |frm_o, |err_o}, 32'h0);
      if (b == 31 + PIPE_DLY - 1) lit("t6_restart", {rx_dv_o[2], rxd_o[23:16]}, 32'h15F);
    end
    idle(4);
    lit("t6_cnt", frm_o[2*CNT_W +: CNT_W], exp_cnt1);

    // Random traffic, enable toggling, idle-period errors and occasional resets
    for (int l = 0; l < LANES; l++) begin left[l] = 0; gap[l] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < PORT_NUM; p++)
        if ($urandom_range(0, 15) == 0) port_en[p] = ~port_en[p];
      for (int l = 0; l < LANES; l++) begin
        if (left[l] == 0 && gap[l] == 0) left[l] = $urandom_range(1, 12);
        in_d[l] = 8'($urandom);
        if (left[l] > 0) begin
          in_v[l] = 1'b1; in_e[l] = ($urandom_range(0, 29) == 0);
          left[l]--;
          if (left[l] == 0) gap[l] = $urandom_range(1, 3);
        end else begin
          in_v[l] = 1'b0; in_e[l] = ($urandom_range(0, 7) == 0);
          gap[l]--;
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
      rst = 1'b0;
    end
    idle(PIPE_DLY + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
